// File: rtl/dpram_port_arbiter_pkg.sv
// rtl/dpram_port_arbiter_pkg.sv - shared types and defaults for the dual-port RAM port arbiter
package dpram_arb_pkg;

  localparam int AW_DEF  = 6;
  localparam int DW_DEF  = 8;
  localparam int TAG_IDW = 3;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic               vld;
    logic               rd;
    logic [TAG_IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// rtl/dpram_port_arbiter_if.sv - requester-side bus of the RAM port arbiter
interface dpram_port_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;

  modport master (
    output req, req_we, req_lock, req_addr, req_wdata,
    input  gnt, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req, req_we, req_lock, req_addr, req_wdata,
    output gnt, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/dpram_port_arbiter_rr_pick.sv
// rtl/dpram_port_arbiter_rr_pick.sv - round-robin winner search starting just above ptr
module rr_priority_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    // ptr itself is visited last, so the previous winner has lowest priority
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!any && req[IW'(cand)]) begin
        any = 1'b1;
        idx = IW'(cand);
      end
    end
    if (any) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// rtl/dpram_port_arbiter.sv - round-robin arbiter for one RAM port; optional burst lock via ARB_LOCK_EN
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dpram_port_arbiter_if.slave  bus,
  output logic [AW-1:0]        ram_addr,
  output logic [DW-1:0]        ram_wdata,
  output logic                 ram_we,
  input  logic [DW-1:0]        ram_q,
  output logic                 busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pick_oh, gnt_vec;
  logic [IW-1:0]   pick_idx, win_idx, ptr_q, ptr_d;
  logic            pick_any, win_any;
  arb_state_e      state_q, state_d;
  tag_t            tag1_q, tag1_d, tag2_q, tag2_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic            ram_we_q, ram_we_d;

`ifdef ARB_LOCK_EN
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          lock_hold;
`else
  logic unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    gnt_vec = pick_oh;
    win_idx = pick_idx;
    win_any = pick_any;
    state_d = state_q;
`ifdef ARB_LOCK_EN
    owner_d   = owner_q;
    burst_d   = burst_q;
    lock_hold = (state_q == ST_LOCK) && bus.req[owner_q] && bus.req_lock[owner_q]
                && (burst_q != BW'(MAX_BURST));
    if (lock_hold) begin
      gnt_vec = NREQ'(1) << owner_q;
      win_idx = owner_q;
      win_any = 1'b1;
      burst_d = burst_q + BW'(1);
    end else begin
      // leaving a burst falls back to plain round-robin from the owner
      state_d = ST_ARB;
      if (pick_any && bus.req_lock[pick_idx]) begin
        state_d = ST_LOCK;
        owner_d = pick_idx;
        burst_d = BW'(1);
      end
    end
`endif
    if (rst) begin
      gnt_vec = '0;
      win_any = 1'b0;
    end

    ptr_d       = win_any ? win_idx : ptr_q;
    ram_we_d    = win_any & bus.req_we[win_idx];
    ram_addr_d  = win_any ? bus.req_addr[win_idx*AW +: AW]  : ram_addr_q;
    ram_wdata_d = win_any ? bus.req_wdata[win_idx*DW +: DW] : ram_wdata_q;

    // only reads enter the tag pipe; writes never produce a response
    tag1_d.vld = win_any & ~bus.req_we[win_idx];
    tag1_d.rd  = ~bus.req_we[win_idx];
    tag1_d.id  = TAG_IDW'(win_idx);
    tag2_d     = tag1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= IW'(NREQ - 1);
      state_q     <= ST_ARB;
      tag1_q      <= '0;
      tag2_q      <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_we_q    <= 1'b0;
`ifdef ARB_LOCK_EN
      owner_q     <= '0;
      burst_q     <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_we_q    <= ram_we_d;
`ifdef ARB_LOCK_EN
      owner_q     <= owner_d;
      burst_q     <= burst_d;
`endif
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.rsp_valid = (tag2_q.vld && tag2_q.rd) ? (NREQ'(1) << tag2_q.id) : '0;
  assign bus.rsp_rdata = ram_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign ram_we        = ram_we_q;
  assign busy          = tag1_q.vld | tag2_q.vld;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb/tb_dpram_port_arbiter.sv - directed self-checking bench for dpram_port_arbiter
module tb_dpram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_q;
  logic       busy;

  int vecs = 0;
  int miscompares = 0;

  dpram_port_arbiter_if #(.NREQ(4), .AW(6), .DW(8)) bus ();

  dpram_port_arbiter #(.NREQ(4), .AW(6), .DW(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RAM: unwritten locations read as 0xA0 | addr; registered read-first output
  logic [7:0]  mem [64];
  logic [63:0] wr_vld;
  always @(posedge clk) begin
    if (rst) wr_vld <= '0;
    else if (ram_we) begin
      mem[ram_addr]    <= ram_wdata;
      wr_vld[ram_addr] <= 1'b1;
    end
    ram_q <= wr_vld[ram_addr] ? mem[ram_addr] : (8'hA0 | {2'b00, ram_addr});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req();
    bus.req = '0; bus.req_we = '0; bus.req_lock = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] a,
                         input logic [7:0] d, input logic lk);
    bus.req[i] = 1'b1;
    bus.req_we[i] = we;
    bus.req_lock[i] = lk;
    bus.req_addr[i*6 +: 6] = a;
    bus.req_wdata[i*8 +: 8] = d;
  endtask

  logic [3:0] exp_lk [6];

  initial begin
    rst = 1'b1;
    clr_req();
    tick();
    set_req(0, 1'b0, 6'h05, 8'h00, 1'b0);
    #1;
    chk("rst_gnt", bus.gnt, 4'b0000);
    chk("rst_rsp", bus.rsp_valid, 4'b0000);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_addr", ram_addr, 6'h00);
    chk("rst_wdata", ram_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    clr_req();
    tick();

    // single read of address 5
    set_req(0, 1'b0, 6'h05, 8'h00, 1'b0);
    #1 chk("rd_gnt", bus.gnt, 4'b0001);
    tick();
    clr_req();
    #1;
    chk("rd_addr", ram_addr, 6'h05);
    chk("rd_we", ram_we, 1'b0);
    chk("rd_busy1", busy, 1'b1);
    chk("rd_rsp_early", bus.rsp_valid, 4'b0000);
    tick();
    chk("rd_rsp", bus.rsp_valid, 4'b0001);
    chk("rd_data", bus.rsp_rdata, 8'hA5);
    chk("rd_busy2", busy, 1'b1);
    tick();
    chk("rd_rsp_done", bus.rsp_valid, 4'b0000);
    chk("rd_busy_done", busy, 1'b0);

    // fairness: ptr is 0, so order is 1,2,3,0,1,2,3,0; addr 16+i reads 0xB0+i
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(16 + i), 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), bus.gnt, 4'b0001 << ((k + 1) % 4));
      if (k >= 2) begin
        chk($sformatf("rr_rsp%0d", k), bus.rsp_valid, 4'b0001 << ((k - 1) % 4));
        chk($sformatf("rr_dat%0d", k), bus.rsp_rdata, 8'hB0 + 8'((k - 1) % 4));
      end
      tick();
    end
    clr_req();
    #1;
    chk("rr_gnt_off", bus.gnt, 4'b0000);
    chk("rr_rsp8", bus.rsp_valid, 4'b1000);
    chk("rr_dat8", bus.rsp_rdata, 8'hB3);
    tick();
    chk("rr_rsp9", bus.rsp_valid, 4'b0001);
    chk("rr_dat9", bus.rsp_rdata, 8'hB0);
    tick();

    // write 0x3C to 0x3F then read it back
    set_req(2, 1'b1, 6'h3F, 8'h3C, 1'b0);
    #1 chk("wr_gnt", bus.gnt, 4'b0100);
    tick();
    set_req(2, 1'b0, 6'h3F, 8'h00, 1'b0);
    #1;
    chk("wr_gnt2", bus.gnt, 4'b0100);
    chk("wr_we", ram_we, 1'b1);
    chk("wr_addr", ram_addr, 6'h3F);
    chk("wr_wdata", ram_wdata, 8'h3C);
    chk("wr_busy", busy, 1'b0);
    tick();
    clr_req();
    #1;
    chk("wr_we_off", ram_we, 1'b0);
    chk("wr_rd_busy", busy, 1'b1);
    tick();
    chk("wr_rsp", bus.rsp_valid, 4'b0100);
    chk("wr_dat", bus.rsp_rdata, 8'h3C);
    tick();

    // idle gap
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("idle_gnt%0d", k), bus.gnt, 4'b0000);
      chk($sformatf("idle_we%0d", k), ram_we, 1'b0);
      chk($sformatf("idle_busy%0d", k), busy, 1'b0);
      chk($sformatf("idle_addr%0d", k), ram_addr, 6'h3F);
      tick();
    end
    // ptr still 2 -> requester 3 wins
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'h07, 8'h00, 1'b0);
    #1 chk("idle_ptr_gnt", bus.gnt, 4'b1000);
    tick();

    // reset the cycle after that read grant
    clr_req();
    rst = 1'b1;
    #1;
    chk("mr_rsp", bus.rsp_valid, 4'b0000);
    chk("mr_busy", busy, 1'b0);
    chk("mr_addr", ram_addr, 6'h00);
    chk("mr_we", ram_we, 1'b0);
    tick();
    chk("mr_rsp2", bus.rsp_valid, 4'b0000);
    rst = 1'b0;
    tick();
    chk("mr_rsp3", bus.rsp_valid, 4'b0000);
    chk("mr_busy3", busy, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'h00, 8'h00, 1'b0);
    #1 chk("mr_gnt", bus.gnt, 4'b0001);
    tick();
    clr_req();

    // req 0,1,3 high with lock on 1; ptr is 0
`ifdef ARB_LOCK_EN
    exp_lk = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
`else
    exp_lk = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
`endif
    set_req(0, 1'b0, 6'h01, 8'h00, 1'b0);
    set_req(1, 1'b0, 6'h02, 8'h00, 1'b1);
    set_req(3, 1'b0, 6'h03, 8'h00, 1'b0);
    for (int k = 0; k < 6; k++) begin
      #1 chk($sformatf("lk_gnt%0d", k), bus.gnt, exp_lk[k]);
      tick();
    end
    clr_req();
    tick();
    tick();
    tick();
    chk("end_busy", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule
